// File: rtl/shift_exec_stage.sv
// Two-stage valid/ready pipelined shift execute unit (SLL/SRL/SRA) for the RV32I datapath.
// Define SHIFT_SRA_EN to build the arithmetic right-shift core; otherwise op 10 is reserved.
module shift_exec_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       in_op_i,
  input  logic [XLEN-1:0]  in_a_i,
  input  logic [XLEN-1:0]  in_b_i,
  input  logic [4:0]       in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  out_res_o,
  output logic [4:0]       out_tag_o,
  output logic             out_err_o,
  output logic [CNT_W-1:0] op_count_o
);

  localparam int unsigned ShW = $clog2(XLEN);

  typedef enum logic [1:0] {
    OpSll = 2'b00,
    OpSrl = 2'b01,
    OpSra = 2'b10,
    OpRsv = 2'b11
  } shift_op_e;

  // Log-depth barrel shifters: stage k shifts by 2**k when shamt bit k is set.
  function automatic logic [XLEN-1:0] sll_core(input logic [XLEN-1:0] a,
                                               input logic [ShW-1:0]  sh);
    logic [XLEN-1:0] r;
    r = a;
    for (int k = 0; k < ShW; k++) begin
      if (sh[k]) r = r << (1 << k);
    end
    return r;
  endfunction

  function automatic logic [XLEN-1:0] srl_core(input logic [XLEN-1:0] a,
                                               input logic [ShW-1:0]  sh);
    logic [XLEN-1:0] r;
    r = a;
    for (int k = 0; k < ShW; k++) begin
      if (sh[k]) r = r >> (1 << k);
    end
    return r;
  endfunction

`ifdef SHIFT_SRA_EN
  function automatic logic [XLEN-1:0] sra_core(input logic [XLEN-1:0] a,
                                               input logic [ShW-1:0]  sh);
    logic [XLEN-1:0] r;
    logic [XLEN-1:0] fill;
    fill = {XLEN{a[XLEN-1]}};
    r    = a;
    for (int k = 0; k < ShW; k++) begin
      if (sh[k]) r = (r >> (1 << k)) | (fill & ~({XLEN{1'b1}} >> (1 << k)));
    end
    return r;
  endfunction
`endif

  // Stage 1 state
  logic            s1_valid_q, s1_valid_d;
  shift_op_e       s1_op_q, s1_op_d;
  logic [XLEN-1:0] s1_a_q, s1_a_d;
  logic [ShW-1:0]  s1_shamt_q, s1_shamt_d;
  logic [4:0]      s1_tag_q, s1_tag_d;

  // Stage 2 state
  logic            s2_valid_q, s2_valid_d;
  logic [XLEN-1:0] s2_res_q, s2_res_d;
  logic [4:0]      s2_tag_q, s2_tag_d;
  logic            s2_err_q, s2_err_d;

  logic [CNT_W-1:0] count_q, count_d;

  logic            s2_advance;
  logic            in_fire;
  logic            out_fire;
  logic [XLEN-1:0] sll_res;
  logic [XLEN-1:0] srl_res;
  logic [XLEN-1:0] shift_res;
  logic            shift_err;
  logic            unused_b_hi;

  assign unused_b_hi = ^in_b_i[XLEN-1:ShW];

  assign s2_advance = !s2_valid_q || out_ready_i;
  assign in_ready_o = !s1_valid_q || s2_advance;
  assign in_fire    = in_valid_i && in_ready_o;
  assign out_fire   = s2_valid_q && out_ready_i;

  assign sll_res = sll_core(s1_a_q, s1_shamt_q);
  assign srl_res = srl_core(s1_a_q, s1_shamt_q);

`ifdef SHIFT_SRA_EN
  logic [XLEN-1:0] sra_res;
  assign sra_res = sra_core(s1_a_q, s1_shamt_q);
`endif

  // Result select; unsupported ops produce zero with the error flag set.
  always_comb begin
    shift_res = '0;
    shift_err = 1'b0;
    unique case (s1_op_q)
      OpSll:   shift_res = sll_res;
      OpSrl:   shift_res = srl_res;
`ifdef SHIFT_SRA_EN
      OpSra:   shift_res = sra_res;
`endif
      default: shift_err = 1'b1;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_shamt_d = s1_shamt_q;
    s1_tag_d   = s1_tag_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_op_d    = shift_op_e'(in_op_i);
      s1_a_d     = in_a_i;
      s1_shamt_d = in_b_i[ShW-1:0];
      s1_tag_d   = in_tag_i;
    end else if (s2_advance) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2 holds its result while downstream stalls.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    s2_tag_d   = s2_tag_q;
    s2_err_d   = s2_err_q;
    if (s2_advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_res_d = shift_res;
        s2_tag_d = s1_tag_q;
        s2_err_d = shift_err;
      end
    end
  end

  assign count_d = out_fire ? count_q + CNT_W'(1) : count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OpSll;
      s1_a_q     <= '0;
      s1_shamt_q <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_tag_q   <= '0;
      s2_err_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_shamt_q <= s1_shamt_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_tag_q   <= s2_tag_d;
      s2_err_q   <= s2_err_d;
      count_q    <= count_d;
    end
  end

  assign out_valid_o = s2_valid_q;
  assign out_res_o   = s2_res_q;
  assign out_tag_o   = s2_tag_q;
  assign out_err_o   = s2_err_q;
  assign op_count_o  = count_q;

  stall_hold_a: assert property (@(posedge clk_i) disable iff (rst_i)
    (out_valid_o && !out_ready_i) |=>
      (out_valid_o && $stable(out_res_o) && $stable(out_tag_o) && $stable(out_err_o)));

endmodule

// File: tb/tb_shift_exec_stage.sv
// Randomised + directed bench for shift_exec_stage against a queue-based reference model.
module tb_shift_exec_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'd0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_res;
  logic [4:0]  out_tag;
  logic        out_err;
  logic [15:0] op_count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    logic        err;
    int          ci;
  } exp_t;

  exp_t        q[$];
  logic [15:0] mcount = '0;
  int          cyc = 0;
  int          last_stall = 0;

  shift_exec_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_op_i    (in_op),
    .in_a_i     (in_a),
    .in_b_i     (in_b),
    .in_tag_i   (in_tag),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_res_o  (out_res),
    .out_tag_o  (out_tag),
    .out_err_o  (out_err),
    .op_count_o (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  // Reference: {err, result} from the ISA rules, SRA as logical shift plus sign mask.
  function automatic logic [32:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    int          sh;
    logic [31:0] ones;
    sh   = int'(b % 32);
    ones = 32'hFFFF_FFFF;
    case (op)
      2'd0: return {1'b0, a << sh};
      2'd1: return {1'b0, a >> sh};
`ifdef SHIFT_SRA_EN
      2'd2: return {1'b0, (a >> sh) | (a[31] ? ~(ones >> sh) : 32'h0)};
`endif
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  always @(negedge clk or posedge rst) begin
    logic [32:0] m;
    if (rst) begin
      q.delete();
      mcount = '0;
      last_stall = cyc;
    end else begin
      cyc++;
      chk("op_count", 64'(op_count), 64'(mcount));
      if (q.size() == 0) begin
        chk("idle_no_valid", 64'(out_valid), 64'(0));
      end else if (out_valid) begin
        chk("model_out", 64'({out_err, out_tag, out_res}), 64'({q[0].err, q[0].tag, q[0].res}));
        if (out_ready) begin
          if (q[0].ci > last_stall) chk("latency", 64'(cyc), 64'(q[0].ci + 2));
          void'(q.pop_front());
          mcount++;
        end
      end
      if (!out_ready) last_stall = cyc;
      if (in_valid && in_ready) begin
        m = model(in_op, in_a, in_b);
        q.push_back('{res: m[31:0], tag: in_tag, err: m[32], ci: cyc});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the op is accepted.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
    logic acc;
    int   n;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    acc      = 1'b0;
    n        = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) fail_timeout("issue");
  endtask

  task automatic wait_res(input string name, input logic [31:0] res, input logic [4:0] tag,
                          input logic err);
    logic got;
    int   n;
    got = 1'b0;
    n   = 0;
    while (!got && n < 30) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        chk(name, 64'({err, tag, res}), 64'({out_err, out_tag, out_res}));
        got = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!got) fail_timeout(name);
  endtask

  initial begin
    int          nin;
    int          nout;
    logic        acc;
    logic [31:0] sra_exp;
    logic        sra_err;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_outputs", 64'({out_err, out_tag, out_res}), 64'(0));
    chk("rst_op_count", 64'(op_count), 64'(0));
    @(posedge clk);
    #1;

    // SRL sweep, back to back
    fork
      begin
        for (int i = 0; i < 8; i++) issue(2'd1, 32'h0001_0001, 32'(i), 5'(i));
      end
      begin
        for (int i = 0; i < 8; i++)
          wait_res($sformatf("sweep%0d", i), 32'h0001_0001 >> i, 5'(i), 1'b0);
      end
    join

    // Mixed ops
`ifdef SHIFT_SRA_EN
    sra_exp = 32'hFF00_1000;
    sra_err = 1'b0;
`else
    sra_exp = 32'h0;
    sra_err = 1'b1;
`endif
    issue(2'd1, 32'hF001_000F, 32'd4, 5'd10);
    wait_res("mix_srl", 32'h0F00_1000, 5'd10, 1'b0);
    issue(2'd0, 32'hF001_000F, 32'd4, 5'd11);
    wait_res("mix_sll", 32'h0010_00F0, 5'd11, 1'b0);
    issue(2'd2, 32'hF001_000F, 32'd4, 5'd12);
    wait_res("mix_sra", sra_exp, 5'd12, sra_err);

    // Extremes
    issue(2'd0, 32'h0000_0001, 32'd31, 5'd13);
    wait_res("sll31", 32'h8000_0000, 5'd13, 1'b0);
    issue(2'd1, 32'h8000_0000, 32'd31, 5'd14);
    wait_res("srl31", 32'h0000_0001, 5'd14, 1'b0);
    issue(2'd0, 32'hAAAA_AAAA, 32'd0, 5'd15);
    wait_res("shamt0", 32'hAAAA_AAAA, 5'd15, 1'b0);
    issue(2'd1, 32'h0000_0080, 32'hFFFF_FFE3, 5'd16);
    wait_res("b_hi_ignored", 32'h0000_0010, 5'd16, 1'b0);

    // Reset mid-flight
    issue(2'd0, 32'h1234_5678, 32'd1, 5'd1);
    issue(2'd1, 32'h1234_5678, 32'd2, 5'd2);
    chk("rst_pre_valid", 64'(out_valid), 64'(1));
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", 64'(out_valid), 64'(0));
    chk("rst_async_count", 64'(op_count), 64'(0));
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_result", 64'(out_valid), 64'(0));
    end
    @(posedge clk);
    #1;

    // Backpressure: 4 ops, out_ready low for 5 cycles
    out_ready = 1'b0;
    nin  = 0;
    nout = 0;
    in_valid = 1'b1;
    in_op    = 2'd1;
    in_a     = $urandom;
    in_b     = $urandom;
    in_tag   = 5'd1;
    for (int c = 0; c < 20 && nout < 4; c++) begin
      if (c == 5) out_ready = 1'b1;
      @(negedge clk);
      if (c == 4) begin
        chk("bp_in_ready", 64'(in_ready), 64'(0));
        chk("bp_accepted", 64'(nin), 64'(2));
      end
      if (c >= 5) begin
        chk("bp_no_gap", 64'(out_valid), 64'(1));
        if (out_valid && out_ready) begin
          chk("bp_tag_order", 64'(out_tag), 64'(nout + 1));
          nout++;
        end
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        nin++;
        if (nin < 4) begin
          in_tag = 5'(nin + 1);
          in_a   = $urandom;
          in_b   = $urandom;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    chk("bp_out_count", 64'(nout), 64'(4));
    chk("bp_op_count", 64'(op_count), 64'(4));

    // Reserved op
    issue(2'd3, 32'hDEAD_BEEF, 32'd5, 5'd7);
    wait_res("reserved", 32'h0, 5'd7, 1'b1);
    chk("reserved_count", 64'(op_count), 64'(5));

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_op     = 2'($urandom_range(0, 3));
      in_a      = $urandom;
      in_b      = $urandom;
      in_tag    = 5'($urandom_range(0, 31));
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk);
      #1;
    end

    // Drain
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && q.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("drain_empty", 64'(q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
